uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- UART transmitter with an 8-bit-wide input FIFO. It is the outbound counterpart of the on-board uart_rx and sends bytes from the FPGA back to the PC over the USB-UART link, for example game state or score reports from game_ctrl.
- It sits in the 100 MHz clk domain.
- Producers push bytes with a valid/ready handshake. The block serialises them as 8N1 frames by default, LSB first, with back-to-back frames and no idle gap.

Parameters:
- CLK_FREQ, 100000000, input clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
  - Bit period DIV = (CLK_FREQ + BAUD/2) / BAUD, integer-rounded; this is 868 at the defaults.
  - DIV >= 2 is required.
- FIFO_DEPTH, 16, FIFO entries. Must be a power of two, >= 2.

Ports:
- clk  in  1  system clock, 100 MHz.
- rstn  in  1  reset, asynchronous, active-low.
- data  in  8  byte to transmit.
- valid  in  1  data is valid this cycle.
- ready  out  1  FIFO can accept a byte (combinational: !full).
- tx  out  1  serial line, registered, idle high.
- busy  out  1  high while the FIFO is non-empty or a frame is in progress.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky; set when valid=1 while ready=0. Cleared only by reset.

Behaviour:
- Reset (rstn=0, asynchronous):
  - tx=1, busy=0, fifo_count=0, overflow=0, ready=1.
  - FSM goes to IDLE; FIFO pointers, baud counter and bit counter all cleared.
  - Reset mid-frame aborts the frame immediately: tx returns high and the FIFO contents are discarded.
- Push: the byte is written on any rising edge with valid & ready.
  - valid & !ready drops the byte and sets overflow on that edge. FIFO state is unchanged.
- Pop: happens only on the IDLE->START transition, or the STOP->START transition for a back-to-back frame.
  - Push and pop on the same edge leave fifo_count unchanged.
  - When full, ready=0 even if a pop occurs on that edge: there is no same-cycle pass-through.
- FSM states: IDLE, START, DATA, [PARITY], STOP. A baud counter counts 0..DIV-1; each state holds tx for exactly DIV cycles.
  - IDLE: tx=1. If the FIFO is non-empty: pop, load the shift register, go to START, and drive tx=0 at the same edge.
  - START: tx=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for DIV cycles per bit, shifting right. After bit 7 go to STOP, or to PARITY if enabled.
  - STOP: tx=1 for DIV cycles. At the end, if the FIFO is non-empty, pop and go to START with no idle gap; otherwise go to IDLE.
- Latency: a byte pushed into an empty FIFO while in IDLE produces the tx falling edge 1 cycle after the push edge. Rationale: the FIFO is non-empty at edge N+1 and tx is registered.
- Frame length: 10*DIV cycles, or 11*DIV with parity.
- busy is registered: busy = (state != IDLE) | (fifo_count != 0), evaluated on the next state.
- fifo_count is updated on the same edge as the push or pop.
- Pointer wrap: the FIFO uses an extra MSB on its pointers to distinguish full from empty. Wrap-around past FIFO_DEPTH is seamless.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - The PARITY state is inserted between DATA and STOP.
  - tx = even parity of the 8 data bits (XOR of the byte) for DIV cycles.
  - Frame = 11*DIV cycles (8E1).
- Undefined:
  - No PARITY state and no parity logic; the frame is 8N1 (10*DIV cycles).

Test Plan:
- Single byte timing (CLK_FREQ=16, BAUD=1, so DIV=16): push 0x55 while IDLE.
  - Required: tx falls 1 cycle after the push.
  - Required line sequence, 16 cycles each: 0 (start), then 1,0,1,0,1,0,1,0 (LSB first), then 1 (stop).
  - Required: busy deasserts after 160 cycles.
- Back-to-back: push 0x00, 0xFF, 0xA5, 0x3C in 4 consecutive cycles.
  - Required: fifo_count peaks at 3.
  - Required: four contiguous frames, each start bit immediately after the previous stop bit, 640 cycles total.
  - Required: decoded bytes match in order.
- Overflow: with FIFO_DEPTH=16, while frame 1 is sending, push 17 more bytes.
  - Required: ready=0 when fifo_count=16; the 17th byte is dropped and overflow=1 (sticky).
  - Required: 17 frames are transmitted in total, and overflow stays 1 afterwards.
- Simultaneous push/pop: with fifo_count=1 and STOP ending, push 0x12 on the pop edge.
  - Required: fifo_count stays 1, and the next frame carries the older byte.
- Reset mid-frame: assert rstn=0 during DATA bit 3 of 0xC3, with 2 bytes queued.
  - Required: tx=1, busy=0, fifo_count=0, overflow=0 immediately.
  - Required: after release, no transmission occurs until a new push.
- Parity (with UART_TX_PARITY_EN defined): push 0x07, then 0x03.
  - Required: parity bit = 1, then 0.
  - Required: each frame is 11*DIV cycles.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// UART transmitter fed by an 8-bit input FIFO. Bytes are accepted with a
// valid/ready handshake and sent LSB first as back-to-back frames (8N1, or
// 8E1 when UART_TX_PARITY_EN is defined) with no idle gap between frames.
//
// Configuration macro: UART_TX_PARITY_EN  (adds an even parity bit, 8E1)
//
// Parameters:
//   CLK_FREQ   input clock frequency in Hz
//   BAUD       line rate in bit/s; bit period DIV = round(CLK_FREQ/BAUD), DIV >= 2
//   FIFO_DEPTH FIFO entries, power of two, >= 2
//
// Ports:
//   clk        system clock
//   rstn       asynchronous active-low reset
//   data       byte to transmit
//   valid      data is valid this cycle
//   ready      FIFO can accept a byte (combinational, !full)
//   tx         registered serial line, idle high
//   busy       registered; FIFO non-empty or frame in progress
//   fifo_count current FIFO occupancy
//   overflow   sticky; set by valid while not ready, cleared only by reset
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [7:0]                    data,
  input  logic                          valid,
  output logic                          ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int DIV   = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic [CW-1:0]    wptr_q, wptr_d;
  logic [CW-1:0]    rptr_q, rptr_d;
  logic             overflow_q, overflow_d;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif
  logic [7:0]       mem_q [FIFO_DEPTH];

  logic             full, empty, push, pop;
  logic [CW-1:0]    count_d;
  logic [7:0]       head;
  logic             cnt_end;

  // Pointers carry an extra MSB so full and empty differ when the indices match.
  assign fifo_count = wptr_q - rptr_q;
  assign full       = (fifo_count == CW'(FIFO_DEPTH));
  assign empty      = (wptr_q == rptr_q);
  assign ready      = ~full;
  assign push       = valid & ~full;
  assign head       = mem_q[rptr_q[AW-1:0]];
  assign cnt_end    = (cnt_q == CNT_MAX);

  assign wptr_d     = wptr_q + CW'(push);
  assign rptr_d     = rptr_q + CW'(pop);
  assign count_d    = wptr_d - rptr_d;
  assign overflow_d = overflow_q | (valid & full);
  assign busy_d     = (state_d != S_IDLE) | (count_d != '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        if (!empty) begin
          // Start bit is driven on the same edge as the pop.
          pop      = 1'b1;
          shift_d  = head;
`ifdef UART_TX_PARITY_EN
          parity_d = ^head;
`endif
          state_d  = S_START;
          tx_d     = 1'b0;
        end
      end
      S_START: begin
        if (cnt_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = parity_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (cnt_end) begin
          cnt_d   = '0;
          state_d = S_STOP;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (cnt_end) begin
          cnt_d = '0;
          if (!empty) begin
            // Back-to-back frame: next start bit follows the stop bit directly.
            pop      = 1'b1;
            shift_d  = head;
`ifdef UART_TX_PARITY_EN
            parity_d = ^head;
`endif
            state_d  = S_START;
            tx_d     = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Data storage carries no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
    parity_q <= parity_d;
`endif
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= data;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLK_FREQ=16, BAUD=1 (DIV=16),
// FIFO_DEPTH=16. Frame layout follows UART_TX_PARITY_EN when defined.
module tb_uart_tx_fifo;

  localparam int DIV = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       tx;
  logic       busy;
  logic [4:0] fifo_count;
  logic       overflow;

  int errors = 0;
  int checks = 0;
  logic last_busy;

  uart_tx_fifo #(
    .CLK_FREQ  (16),
    .BAUD      (1),
    .FIFO_DEPTH(16)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .tx        (tx),
    .busy      (busy),
    .fifo_count(fifo_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_level(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Called right after the edge that drove the start bit (minus skip cycles
  // already elapsed). Checks every line bit is held for DIV cycles, decodes the
  // byte mid-bit, and optionally pushes a byte on the frame's final edge.
  task automatic expect_frame(input logic [7:0] b, input int skip, input bit end_push,
                              input logic [7:0] end_data, input string tag);
    logic [7:0] dec;
    bit ok;
    logic lvl;
    int j0;
    dec = '0;
    for (int i = 0; i < FRAME_BITS; i++) begin
      lvl = exp_level(b, i);
      ok  = 1'b1;
      j0  = (i == 0) ? skip : 0;
      for (int j = j0; j < DIV; j++) begin
        if (tx !== lvl) ok = 1'b0;
        if (j == 8 && i >= 1 && i <= 8) dec[i-1] = tx;
        if (i == FRAME_BITS - 1 && j == DIV - 1) begin
          last_busy = busy;
          if (end_push) begin
            data  = end_data;
            valid = 1'b1;
          end
        end
        tick();
        if (end_push) valid = 1'b0;
      end
      if (j0 < DIV) check($sformatf("%s bit%0d", tag, i), {31'd0, ok}, 32'd1);
    end
    check($sformatf("%s decoded", tag), {24'd0, dec}, {24'd0, b});
  endtask

  initial begin
    int peak;
    bit idle_ok;
    rstn  = 1'b0;
    valid = 1'b0;
    data  = 8'h00;
    last_busy = 1'b0;
    tick();
    tick();
    check("reset tx", {31'd0, tx}, 32'd1);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset count", {27'd0, fifo_count}, 32'd0);
    check("reset overflow", {31'd0, overflow}, 32'd0);
    check("reset ready", {31'd0, ready}, 32'd1);
    rstn = 1'b1;
    tick();

    // Single byte 0x55: tx falls one cycle after the push edge.
    data = 8'h55; valid = 1'b1;
    tick();
    valid = 1'b0;
    check("single tx before fall", {31'd0, tx}, 32'd1);
    check("single count", {27'd0, fifo_count}, 32'd1);
    check("single busy", {31'd0, busy}, 32'd1);
    tick();
    check("single tx fall", {31'd0, tx}, 32'd0);
    expect_frame(8'h55, 0, 1'b0, 8'h00, "single");
    check("single busy last cycle", {31'd0, last_busy}, 32'd1);
    check("single busy end", {31'd0, busy}, 32'd0);
    check("single tx idle", {31'd0, tx}, 32'd1);

    // Back-to-back: four pushes in consecutive cycles.
    peak = 0;
    data = 8'h00; valid = 1'b1; tick(); if (int'(fifo_count) > peak) peak = int'(fifo_count);
    data = 8'hFF;               tick(); if (int'(fifo_count) > peak) peak = int'(fifo_count);
    data = 8'hA5;               tick(); if (int'(fifo_count) > peak) peak = int'(fifo_count);
    data = 8'h3C;               tick(); if (int'(fifo_count) > peak) peak = int'(fifo_count);
    valid = 1'b0;
    check("b2b peak count", peak, 32'd3);
    expect_frame(8'h00, 2, 1'b0, 8'h00, "b2b0");
    expect_frame(8'hFF, 0, 1'b0, 8'h00, "b2b1");
    expect_frame(8'hA5, 0, 1'b0, 8'h00, "b2b2");
    expect_frame(8'h3C, 0, 1'b0, 8'h00, "b2b3");
    check("b2b busy end", {31'd0, busy}, 32'd0);

    // Overflow: one frame in flight, then 17 pushes; the 17th is dropped.
    data = 8'h80; valid = 1'b1;
    tick();
    for (int k = 1; k <= 17; k++) begin
      data = 8'h10 + 8'(k);
      tick();
      if (k == 16) begin
        check("ovf count full", {27'd0, fifo_count}, 32'd16);
        check("ovf ready full", {31'd0, ready}, 32'd0);
        check("ovf not yet", {31'd0, overflow}, 32'd0);
      end
    end
    valid = 1'b0;
    check("ovf set", {31'd0, overflow}, 32'd1);
    check("ovf count kept", {27'd0, fifo_count}, 32'd16);
    expect_frame(8'h80, 16, 1'b0, 8'h00, "ovf0");
    for (int k = 1; k <= 16; k++) begin
      expect_frame(8'h10 + 8'(k), 0, 1'b0, 8'h00, $sformatf("ovf%0d", k));
    end
    check("ovf busy end", {31'd0, busy}, 32'd0);
    check("ovf sticky", {31'd0, overflow}, 32'd1);

    // Simultaneous push/pop at the end of STOP with one byte queued.
    data = 8'h34; valid = 1'b1; tick();
    data = 8'h56;               tick();
    valid = 1'b0;
    check("pp count before", {27'd0, fifo_count}, 32'd1);
    expect_frame(8'h34, 0, 1'b1, 8'h12, "pp0");
    check("pp count after", {27'd0, fifo_count}, 32'd1);
    expect_frame(8'h56, 0, 1'b0, 8'h00, "pp1");
    expect_frame(8'h12, 0, 1'b0, 8'h00, "pp2");
    check("pp busy end", {31'd0, busy}, 32'd0);

    // Reset during DATA bit 3 of 0xC3 with two bytes queued.
    data = 8'hC3; valid = 1'b1; tick();
    data = 8'hAA;               tick();
    data = 8'hBB;               tick();
    valid = 1'b0;
    for (int k = 0; k < 70; k++) tick();
    check("rst pre tx bit3", {31'd0, tx}, 32'd0);
    check("rst pre count", {27'd0, fifo_count}, 32'd2);
    rstn = 1'b0;
    #1;
    check("rst tx", {31'd0, tx}, 32'd1);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst count", {27'd0, fifo_count}, 32'd0);
    check("rst overflow", {31'd0, overflow}, 32'd0);
    check("rst ready", {31'd0, ready}, 32'd1);
    tick();
    tick();
    rstn = 1'b1;
    idle_ok = 1'b1;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 5'd0) idle_ok = 1'b0;
    end
    check("rst stays idle", {31'd0, idle_ok}, 32'd1);
    data = 8'h5A; valid = 1'b1;
    tick();
    valid = 1'b0;
    check("rst new tx before fall", {31'd0, tx}, 32'd1);
    tick();
    check("rst new tx fall", {31'd0, tx}, 32'd0);
    expect_frame(8'h5A, 0, 1'b0, 8'h00, "rstnew");

    // Odd/even byte pair (parity bits 1 then 0 when parity is enabled).
    data = 8'h07; valid = 1'b1; tick();
    data = 8'h03;               tick();
    valid = 1'b0;
    expect_frame(8'h07, 0, 1'b0, 8'h00, "par0");
    expect_frame(8'h03, 0, 1'b0, 8'h00, "par1");
    check("par busy end", {31'd0, busy}, 32'd0);
    check("par tx idle", {31'd0, tx}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
